// File: rtl/bus_generator_arbiter.sv
// Multi-bus packet arbiter.
// Each bus runs its own three-state engine:
//   IDLE -> POP  : a round-robin winner is granted and its head packet is captured.
//   POP  -> PUSH : the captured packet is delivered to its destination driver(s).
//   PUSH -> IDLE
// pop and push come straight from flops, so each strobe lasts exactly one cycle.
// A bus can therefore move at most one packet every three cycles.
module bus_generator_arbiter #(
  parameter int         BITS    = 1,
  parameter int         DRIVERS = 4,
  parameter int         PCKG    = 16,
  parameter logic [7:0] BROD    = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BITS*DRIVERS-1:0]       pndng,
  input  logic [BITS*DRIVERS*PCKG-1:0]  D_pop,
  output logic [BITS*DRIVERS-1:0]       pop,
  output logic [BITS*DRIVERS-1:0]       push,
  output logic [BITS*DRIVERS*PCKG-1:0]  D_push
);

  // Width of a driver index; it is at least 1 so that DRIVERS == 1 still elaborates.
  localparam int PW = (DRIVERS > 1) ? $clog2(DRIVERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < BITS; gi++) begin : g_bus
      state_t            state_q, state_d;
      logic [PW-1:0]     ptr_q, ptr_d;
      logic [PW-1:0]     src_q, src_d;
      logic [PCKG-1:0]   pkt_q, pkt_d;
      logic [DRIVERS-1:0] pop_q, pop_d;
      logic [DRIVERS-1:0] push_q, push_d;

      logic [DRIVERS-1:0] req;
      logic               found;
      logic [PW-1:0]      winner;
      logic [PCKG-1:0]    win_pkt;
      logic [7:0]         dest;

      assign req  = pndng[gi*DRIVERS +: DRIVERS];
      assign dest = pkt_q[PCKG-1 -: 8];

      // Round-robin search.
      // The search starts at the driver after the last winner and wraps around.
      // The winner's head packet is selected in the same pass.
      always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        winner  = ptr_q;
        win_pkt = '0;
        for (int k = 1; k <= DRIVERS; k++) begin
          idx = int'(ptr_q) + k;
          if (idx >= DRIVERS) idx = idx - DRIVERS;
          if (!found && req[idx]) begin
            found   = 1'b1;
            winner  = PW'(idx);
            win_pkt = D_pop[(gi*DRIVERS + idx)*PCKG +: PCKG];
          end
        end
      end

      // Next-state logic and strobe generation.
      // The strobes are computed one cycle ahead so that they are registered.
      always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        pkt_d   = pkt_q;
        pop_d   = '0;
        push_d  = '0;
        case (state_q)
          IDLE: begin
            if (found) begin
              state_d        = POP;
              ptr_d          = winner;
              src_d          = winner;
              pkt_d          = win_pkt;
              pop_d[winner]  = 1'b1;
            end
          end
          POP: begin
            state_d = PUSH;
            // The broadcast ID is tested first, so it wins even if it also looks like a valid driver ID.
            if (dest == BROD) begin
              push_d        = '1;
              push_d[src_q] = 1'b0;
            end else begin
              // Any ID outside 0..DRIVERS-1 matches no driver, so the packet is silently dropped.
              for (int d = 0; d < DRIVERS; d++) begin
                push_d[d] = (int'(dest) == d);
              end
            end
          end
          PUSH: begin
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end

      // Per-bus state register.
      // Reset clears everything immediately; this also discards any packet in flight.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= IDLE;
          ptr_q   <= PW'(DRIVERS - 1);
          src_q   <= '0;
          pkt_q   <= '0;
          pop_q   <= '0;
          push_q  <= '0;
        end else begin
          state_q <= state_d;
          ptr_q   <= ptr_d;
          src_q   <= src_d;
          pkt_q   <= pkt_d;
          pop_q   <= pop_d;
          push_q  <= push_d;
        end
      end

      assign pop[gi*DRIVERS +: DRIVERS]  = pop_q;
      assign push[gi*DRIVERS +: DRIVERS] = push_q;

      genvar gj;
      for (gj = 0; gj < DRIVERS; gj++) begin : g_drv
        assign D_push[(gi*DRIVERS + gj)*PCKG +: PCKG] = pkt_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Directed bench for bus_generator_arbiter.
// Configuration: two buses, two drivers per bus, 16-bit packets, broadcast ID 8'h10.
module tb_bus_generator_arbiter;

  localparam int         BITS    = 2;
  localparam int         DRIVERS = 2;
  localparam int         PCKG    = 16;
  localparam logic [7:0] BROD    = 8'h10;

  logic                         clk;
  logic                         reset;
  logic [BITS*DRIVERS-1:0]      pndng;
  logic [BITS*DRIVERS*PCKG-1:0] D_pop;
  logic [BITS*DRIVERS-1:0]      pop;
  logic [BITS*DRIVERS-1:0]      push;
  logic [BITS*DRIVERS*PCKG-1:0] D_push;

  int checks;
  int errors;

  bus_generator_arbiter #(
    .BITS(BITS), .DRIVERS(DRIVERS), .PCKG(PCKG), .BROD(BROD)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected pop values while drivers 0 and 1 of bus 0 are continuously pending.
  // The round-robin pointer favours driver 0 first.
  logic [3:0] fair_pop [10] = '{4'b0001, 4'b0000, 4'b0000,
                                4'b0010, 4'b0000, 4'b0000,
                                4'b0001, 4'b0000, 4'b0000,
                                4'b0010};

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    pndng  = '0;
    D_pop  = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pop",    {60'd0, pop},  64'd0);
    check_eq("rst_push",   {60'd0, push}, 64'd0);
    check_eq("rst_dpush",  D_push,        64'd0);
    reset = 1'b1;
    tick();
    check_eq("idle_pop",   {60'd0, pop},  64'd0);

    // Unicast: bus0 drv0 sends to drv1.
    D_pop[15:0] = 16'h01AB;
    pndng       = 4'b0001;
    tick();
    check_eq("uni_pop",    {60'd0, pop},  64'h1);
    check_eq("uni_nopush", {60'd0, push}, 64'h0);
    pndng = '0;
    tick();
    check_eq("uni_pop0",   {60'd0, pop},  64'h0);
    check_eq("uni_push",   {60'd0, push}, 64'h2);
    check_eq("uni_data1",  {48'd0, D_push[31:16]}, 64'h01AB);
    tick();
    check_eq("uni_done",   {60'd0, push}, 64'h0);

    // Broadcast: bus0 drv1 sends to every other driver, which is drv0 only.
    D_pop[31:16] = 16'h10CD;
    pndng        = 4'b0010;
    tick();
    check_eq("brd_pop",    {60'd0, pop},  64'h2);
    pndng = '0;
    tick();
    check_eq("brd_push",   {60'd0, push}, 64'h1);
    check_eq("brd_data0",  {48'd0, D_push[15:0]}, 64'h10CD);
    tick();

    // Fairness: both drivers of bus 0 stay pending.
    D_pop[15:0]  = 16'h0111;
    D_pop[31:16] = 16'h0022;
    pndng        = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("fair_pop%0d", i), {60'd0, pop}, {60'd0, fair_pop[i]});
    end
    pndng = '0;
    tick();
    check_eq("fair_push",  {60'd0, push}, 64'h1);
    tick();

    // Invalid destination: the packet is popped but never pushed.
    D_pop[15:0] = 16'h05EE;
    pndng       = 4'b0001;
    tick();
    check_eq("inv_pop",    {60'd0, pop},  64'h1);
    pndng = '0;
    tick();
    check_eq("inv_push",   {60'd0, push}, 64'h0);
    tick();
    check_eq("inv_push2",  {60'd0, push}, 64'h0);

    // Independence: both buses transfer in the same cycles.
    D_pop        = '0;
    D_pop[15:0]  = 16'h0155;
    D_pop[63:48] = 16'h0066;
    pndng        = 4'b1001;
    tick();
    check_eq("ind_pop",    {60'd0, pop},  64'h9);
    pndng = '0;
    tick();
    check_eq("ind_push",   {60'd0, push}, 64'h6);
    check_eq("ind_dpush",  D_push,        64'h0066_0066_0155_0155);
    tick();

    // Reset during the POP cycle aborts the transfer at once.
    D_pop[31:16] = 16'h0099;
    pndng        = 4'b0010;
    tick();
    check_eq("rpop_pop",   {60'd0, pop},  64'h2);
    pndng = '0;
    #2 reset = 1'b0;
    #1;
    check_eq("rab_pop",    {60'd0, pop},  64'h0);
    check_eq("rab_push",   {60'd0, push}, 64'h0);
    check_eq("rab_dpush",  D_push,        64'h0);
    @(negedge clk);
    check_eq("rab_push2",  {60'd0, push}, 64'h0);
    reset        = 1'b1;
    D_pop[15:0]  = 16'h0177;
    pndng        = 4'b0011;
    tick();
    check_eq("rel_pop",    {60'd0, pop},  64'h1);
    pndng = '0;
    tick();
    check_eq("rel_push",   {60'd0, push}, 64'h2);
    check_eq("rel_data",   {48'd0, D_push[31:16]}, 64'h0177);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_generator_arbiter.md
BUS_GENERATOR_ARBITER -- requirements
Module: bus_generator_arbiter

Interface
REQ-001 SHALL have parameter BITS, default 1: number of independent buses.
REQ-002 SHALL have parameter DRIVERS, default 4: number of drivers per bus.
REQ-003 SHALL have parameter PCKG, default 16: packet width in bits, minimum 9.
REQ-004 SHALL have parameter BROD, default 8'hFF: destination ID meaning broadcast.
REQ-005 SHALL have clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-006 SHALL have reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have pndng, input, BITS*DRIVERS bits: driver has a packet waiting; index b*DRIVERS+d is bus b, driver d.
REQ-008 SHALL have D_pop, input, BITS*DRIVERS*PCKG bits: head packet of each driver; slice (b*DRIVERS+d)*PCKG +: PCKG.
REQ-009 SHALL have pop, output, BITS*DRIVERS bits: one-cycle acknowledge that the driver's head packet was taken.
REQ-010 SHALL have push, output, BITS*DRIVERS bits: one-cycle strobe delivering a packet to a driver.
REQ-011 SHALL have D_push, output, BITS*DRIVERS*PCKG bits: packet presented to each driver, same slicing as D_pop.

Function
REQ-012 SHALL give each bus its own arbiter: state, round-robin pointer and packet register, with no interaction between buses.
REQ-013 SHALL take the destination ID of a packet from bits [PCKG-1:PCKG-8].
REQ-014 SHALL use per-bus states IDLE, POP and PUSH.
REQ-015 IDLE: on a rising edge with any pndng of the bus high, SHALL do all of the following on that edge:
  - choose the winner by round-robin, searching from pointer+1 upward with wrap-around;
  - latch the winner's D_pop into the packet register;
  - record the winner as source and set pointer = winner;
  - enter POP.
REQ-016 IDLE with no pndng SHALL stay in IDLE.
REQ-017 POP: pop[source] SHALL be 1 for exactly this one cycle; pndng SHALL be ignored; next state is PUSH.
REQ-018 PUSH: for exactly this one cycle, push SHALL assert as follows, and next state is IDLE:
  - destination ID < DRIVERS: assert push[destination];
  - destination ID == BROD: assert push on every driver of the bus except the source;
  - any other ID: assert no push (packet dropped).
REQ-019 Unicast to the source's own ID SHALL be delivered to the source.
REQ-020 SHALL drive D_push of every driver on a bus from that bus's packet register at all times.
REQ-021 pop and push SHALL be registered outputs; throughput is one packet per bus every 3 cycles.
REQ-022 SHALL give BROD precedence if BROD < DRIVERS.
REQ-023 The pop-to-push latency SHALL be 1 cycle.

Reset
REQ-024 While reset=0, SHALL hold all pop=0, push=0 and D_push=0, with every bus in IDLE.
REQ-025 While reset=0, each pointer SHALL be DRIVERS-1 so that driver 0 has first priority.
REQ-026 Reset asserted mid-transfer SHALL abort immediately; the in-flight packet is discarded with no further pop or push.
REQ-027 After reset releases, arbitration SHALL begin at the first rising edge with pndng high.

Verification (BITS=2, DRIVERS=2, PCKG=16, BROD=8'h10)
REQ-028 Unicast: bus 0, driver 0 pending with 16'h01AB -> next cycle pop[0]=1 for 1 cycle; following cycle push[1]=1 for 1 cycle with D_push slice 1 = 16'h01AB.
REQ-029 Broadcast: bus 0, driver 1 pending with 16'h10CD -> pop[1] for 1 cycle, then push[0] only, with data 16'h10CD.
REQ-030 Fairness: bus 0, drivers 0 and 1 continuously pending -> pop grants alternate 0,1,0,1 with 3-cycle spacing.
REQ-031 Invalid destination: packet 16'h05EE -> pop asserted; push stays 0 on every driver.
REQ-032 Independence: both buses pending together -> both complete in the same cycles; bus 1 uses bits 2-3 and does not disturb bus 0.
REQ-033 Reset: reset=0 during the POP cycle -> pop and push drop to 0 at once; after release, driver 0 wins first.
